// File: rtl/button_conditioner.sv
// Per-bit synchroniser, debouncer and rise/fall edge detector for the car-control switches.
// Optional auto-repeat pulses are built only when BUTTON_REPEAT_EN is defined.
module button_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] repeat_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] mismatch;
    logic [WIDTH-1:0] expire;

    // expire marks the edge on which a bit's accepted level toggles.
    // NOTE: every always_comb output gets a default before any conditional
    // assignment so no path can leave it unassigned and infer a latch.
    always_comb begin
        mismatch = s2 ^ level;
        expire   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            expire[i] = mismatch[i] && (cnt[i] == CNT_LAST);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= '0;
            s2    <= '0;
            level <= '0;
            rise  <= '0;
            fall  <= '0;
            // NOTE: the counter array is reset because a stale count would
            // shorten the first debounce window after reset.
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1    <= raw;
            s2    <= s1;
            level <= level ^ expire;
            rise  <= expire & ~level;
            fall  <= expire & level;
            for (int i = 0; i < WIDTH; i++) begin
                if (!mismatch[i] || expire[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef BUTTON_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]    rcnt [WIDTH];
    logic [WIDTH-1:0] rphase;   // 0: waiting for first repeat, 1: periodic repeats
    logic [WIDTH-1:0] rfire;

    // A bit falling on this edge must not fire, even if its slot is due.
    always_comb begin
        rfire = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rfire[i] = level[i] && !expire[i] &&
                       (rcnt[i] == (rphase[i] ? PERIOD_LAST : DELAY_LAST));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rphase       <= '0;
            repeat_pulse <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                rcnt[i] <= '0;
            end
        end else begin
            repeat_pulse <= rfire;
            for (int i = 0; i < WIDTH; i++) begin
                if (!level[i] || expire[i]) begin
                    rcnt[i]   <= '0;
                    rphase[i] <= 1'b0;
                end else if (rfire[i]) begin
                    rcnt[i]   <= '0;
                    rphase[i] <= 1'b1;
                end else begin
                    rcnt[i] <= rcnt[i] + RW'(1);
                end
            end
        end
    end
`else
    assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: table of {raw, hold cycles, expected outputs}
// plus hand-written sequences for auto-repeat and reset mid-count.
module tb_button_conditioner;

    localparam int WIDTH = 8;

`ifdef BUTTON_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] repeat_pulse;

    int errors = 0;
    int checks = 0;

    button_conditioner #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .raw         (raw),
        .level       (level),
        .rise        (rise),
        .fall        (fall),
        .repeat_pulse(repeat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] raw;
        int               cycles;
        logic [WIDTH-1:0] level;
        logic [WIDTH-1:0] rise_or;
        logic [WIDTH-1:0] fall_or;
    } vec_t;

    task automatic check(input string name, input logic [WIDTH-1:0] actual,
                         input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[21];
    logic [WIDTH-1:0] r_or, f_or, p_or, exp_rep, exp_fall;

    initial begin
        // Levels start at 0 after reset; each rise lands on the 6th edge after raw changes.
        tbl[0]  = '{8'h00, 20, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{8'h01,  5, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{8'h01,  1, 8'h01, 8'h01, 8'h00};
        tbl[3]  = '{8'h01,  1, 8'h01, 8'h00, 8'h00};
        tbl[4]  = '{8'h00,  5, 8'h01, 8'h00, 8'h00};
        tbl[5]  = '{8'h00,  1, 8'h00, 8'h00, 8'h01};
        tbl[6]  = '{8'h00,  3, 8'h00, 8'h00, 8'h00};
        tbl[7]  = '{8'h08,  3, 8'h00, 8'h00, 8'h00};
        tbl[8]  = '{8'h00, 10, 8'h00, 8'h00, 8'h00};
        tbl[9]  = '{8'h08,  5, 8'h00, 8'h00, 8'h00};
        tbl[10] = '{8'h08,  1, 8'h08, 8'h08, 8'h00};
        tbl[11] = '{8'h08,  1, 8'h08, 8'h00, 8'h00};
        tbl[12] = '{8'h00,  5, 8'h08, 8'h00, 8'h00};
        tbl[13] = '{8'h00,  1, 8'h00, 8'h00, 8'h08};
        tbl[14] = '{8'h00,  2, 8'h00, 8'h00, 8'h00};
        tbl[15] = '{8'h81,  5, 8'h00, 8'h00, 8'h00};
        tbl[16] = '{8'h81,  1, 8'h81, 8'h81, 8'h00};
        tbl[17] = '{8'h81,  2, 8'h81, 8'h00, 8'h00};
        tbl[18] = '{8'h00,  5, 8'h81, 8'h00, 8'h00};
        tbl[19] = '{8'h00,  1, 8'h00, 8'h00, 8'h81};
        tbl[20] = '{8'h00,  2, 8'h00, 8'h00, 8'h00};

        rst = 1'b0;
        raw = '0;
        #1;
        check("reset level", level, 8'h00);
        check("reset rise", rise, 8'h00);
        check("reset fall", fall, 8'h00);
        check("reset repeat", repeat_pulse, 8'h00);
        step();
        step();
        rst = 1'b1;

        for (int v = 0; v < 21; v++) begin
            raw  = tbl[v].raw;
            r_or = '0;
            f_or = '0;
            p_or = '0;
            for (int c = 0; c < tbl[v].cycles; c++) begin
                step();
                r_or |= rise;
                f_or |= fall;
                p_or |= repeat_pulse;
            end
            check($sformatf("vec%0d level", v), level, tbl[v].level);
            check($sformatf("vec%0d rise", v), r_or, tbl[v].rise_or);
            check($sformatf("vec%0d fall", v), f_or, tbl[v].fall_or);
            check($sformatf("vec%0d repeat", v), p_or, 8'h00);
        end

        // Auto-repeat on bit 2: pulses at rise+10, +13, ... until the fall edge at rise+37,
        // whose own slot (37) must be suppressed.
        raw = 8'h04;
        for (int c = 0; c < 6; c++) step();
        check("repeat seq rise", rise, 8'h04);
        check("repeat seq no dup", repeat_pulse, 8'h00);
        for (int j = 1; j <= 48; j++) begin
            step();
            if (j == 31) raw = 8'h00;
            exp_rep  = (REP_ON && j >= 10 && j < 37 && ((j - 10) % 3 == 0)) ? 8'h04 : 8'h00;
            exp_fall = (j == 37) ? 8'h04 : 8'h00;
            check($sformatf("repeat j=%0d", j), repeat_pulse, exp_rep);
            check($sformatf("repeat fall j=%0d", j), fall, exp_fall);
        end
        check("repeat seq level end", level, 8'h00);

        // Reset mid-count: bit 0 accepted, bit 1 counter at 2 when rst drops.
        raw = 8'h01;
        for (int c = 0; c < 8; c++) step();
        check("pre-reset level", level, 8'h01);
        raw = 8'h03;
        for (int c = 0; c < 4; c++) step();
        rst = 1'b0;
        #2;
        check("async reset level", level, 8'h00);
        check("async reset rise", rise, 8'h00);
        check("async reset fall", fall, 8'h00);
        check("async reset repeat", repeat_pulse, 8'h00);
        step();
        step();
        check("held reset level", level, 8'h00);
        rst = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            check($sformatf("post-reset level e%0d", e), level, (e >= 6) ? 8'h03 : 8'h00);
            check($sformatf("post-reset rise e%0d", e), rise, (e == 6) ? 8'h03 : 8'h00);
            check($sformatf("post-reset fall e%0d", e), fall, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
